// File: rtl/uart_pkg.sv
// Shared UART receive types, idle level and default frame geometry.
package uart_pkg;

  localparam int unsigned DATA_BITS_DEF  = 8;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, oversample tick counter and mid-bit sample strobe.
// UART_RX_MAJORITY_VOTE_EN: strobe one tick late with the 2-of-3 vote around mid-bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic baud_tick_i,
  input  logic rx_i,
  input  logic cnt_clr_i,
  output logic line_o,
  output logic sample_valid_c_o,
  output logic sample_bit_c_o
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned MID   = OVERSAMPLE / 2 - 1;

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= UART_IDLE_LEVEL;
      sync2_q <= UART_IDLE_LEVEL;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  // Counter is held at 0 while idle so mid-bit lands half a bit after the start edge.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (baud_tick_i) begin
      cnt_d = (cnt_q == CNT_W'(OVERSAMPLE - 1)) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign line_o = sync2_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] vote_q, vote_d;

  always_comb begin
    vote_d = vote_q;
    if (baud_tick_i && (cnt_q == CNT_W'(MID - 1))) vote_d[0] = sync2_q;
    if (baud_tick_i && (cnt_q == CNT_W'(MID)))     vote_d[1] = sync2_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) vote_q <= '0;
    else          vote_q <= vote_d;
  end

  assign sample_valid_c_o = baud_tick_i && !cnt_clr_i && (cnt_q == CNT_W'(MID + 1));
  assign sample_bit_c_o   = maj3(vote_q[0], vote_q[1], sync2_q);
`else
  assign sample_valid_c_o = baud_tick_i && !cnt_clr_i && (cnt_q == CNT_W'(MID));
  assign sample_bit_c_o   = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive frame assembler: start, LSB-first data, parity, stop.
// UART_RX_MAJORITY_VOTE_EN selects 2-of-3 bit voting inside uart_rx_sampler.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_bit,
  output logic                 error_check_en,
  output logic                 rx_done,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  rx_state_t            state_q, state_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_par_q, rx_par_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;
  logic                 ecen_q, ecen_d;
  logic                 busy_q, busy_d;

  logic line, smp_valid_c, smp_bit_c, start_low_c;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk_i           (PCLK),
    .rst_n_i         (PRESETn),
    .baud_tick_i     (baud_tick),
    .rx_i            (rx_in),
    .cnt_clr_i       (state_q == IDLE),
    .line_o          (line),
    .sample_valid_c_o(smp_valid_c),
    .sample_bit_c_o  (smp_bit_c)
  );

  assign start_low_c = baud_tick && (line != UART_IDLE_LEVEL);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      rx_data_q <= '0;
      rx_par_q  <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
      ecen_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      rx_data_q <= rx_data_d;
      rx_par_q  <= rx_par_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
      ecen_q    <= ecen_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state: each non-idle state advances on the sampler's mid-bit strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_low_c) state_d = START;
      START:   if (smp_valid_c) state_d = (smp_bit_c == UART_IDLE_LEVEL) ? IDLE : DATA;
      DATA:    if (smp_valid_c && (bit_idx_q == IDX_W'(DATA_BITS - 1))) state_d = PARITY;
      PARITY:  if (smp_valid_c) state_d = STOP;
      STOP:    if (smp_valid_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; result registers only move at stop mid-bit.
  always_comb begin
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    rx_data_d = rx_data_q;
    rx_par_d  = rx_par_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;
    ecen_d    = 1'b0;
    busy_d    = (state_d != IDLE);
    case (state_q)
      START: if (smp_valid_c) bit_idx_d = '0;
      DATA: begin
        if (smp_valid_c) begin
          shift_d[bit_idx_q] = smp_bit_c;
          bit_idx_d          = bit_idx_q + IDX_W'(1);
        end
      end
      PARITY: if (smp_valid_c) par_d = smp_bit_c;
      STOP: begin
        if (smp_valid_c) begin
          rx_data_d = shift_q;
          rx_par_d  = par_q;
          ferr_d    = ~smp_bit_c;
          done_d    = 1'b1;
          ecen_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rx_data        = rx_data_q;
  assign rx_parity_bit  = rx_par_q;
  assign error_check_en = ecen_q;
  assign rx_done        = done_q;
  assign framing_error  = ferr_q;
  assign rx_busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: vector table, corner-case sequences and random frames.
module tb_uart_rx_deserializer;

  localparam int unsigned DB        = 8;
  localparam int unsigned OS        = 16;
  localparam int unsigned TICK_CLKS = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          baud_tick;
  logic          rx_in;
  logic [DB-1:0] rx_data;
  logic          rx_parity_bit;
  logic          error_check_en;
  logic          rx_done;
  logic          framing_error;
  logic          rx_busy;

  always #5 PCLK = ~PCLK;

  logic [1:0] div_q = 2'd0;
  always @(posedge PCLK) div_q <= div_q + 2'd1;
  assign baud_tick = (div_q == 2'd3);

  uart_rx_deserializer #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .baud_tick     (baud_tick),
    .rx_in         (rx_in),
    .rx_data       (rx_data),
    .rx_parity_bit (rx_parity_bit),
    .error_check_en(error_check_en),
    .rx_done       (rx_done),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       ferr;
    logic       perr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         expected_frames = 0;
  logic [7:0] last_data = 8'h00;
  exp_t       exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Scoreboard: every frame end must match the oldest outstanding expectation.
  exp_t e;
  always @(negedge PCLK) begin
    if (PRESETn === 1'b1) begin
      if (error_check_en === 1'b1 && rx_done !== 1'b1)
        chk("ecen_without_done", 32'(rx_done), 32'(error_check_en));
      if (rx_done === 1'b1) begin
        done_cnt++;
        chk("ecen_with_done", 32'(error_check_en), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e.data));
          chk("rx_parity_bit", 32'(rx_parity_bit), 32'(e.par));
          chk("framing_error", 32'(framing_error), 32'(e.ferr));
          chk("checker_parity_err", 32'(^rx_data ^ rx_parity_bit), 32'(e.perr));
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * TICK_CLKS) @(negedge PCLK);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic p, input logic ferr, input logic perr);
    exp_t x;
    x.data = d;
    x.par  = p;
    x.ferr = ferr;
    x.perr = perr;
    exp_q.push_back(x);
    last_data = d;
    expected_frames++;
  endtask

  vec_t       tbl[4];
  int         d0;
  logic [7:0] rd;
  logic       rp, rs;

  initial begin
    rx_in   = 1'b1;
    PRESETn = 1'b0;
    repeat (5) @(negedge PCLK);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_parity", 32'(rx_parity_bit), 32'd0);
    chk("rst_ecen", 32'(error_check_en), 32'd0);
    chk("rst_done", 32'(rx_done), 32'd0);
    chk("rst_ferr", 32'(framing_error), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    PRESETn = 1'b1;
    wait_ticks(4);

    // data, parity, stop, expected framing error, expected even-parity checker error
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      push_exp(tbl[i].data, tbl[i].par, tbl[i].exp_ferr, tbl[i].exp_perr);
      send_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
      rx_in = 1'b1;
      wait_ticks(tbl[i].stop ? 4 : 24);
      chk("tbl_done_count", 32'(done_cnt), 32'(expected_frames));
    end

    // False start: short low pulse must abort without touching results.
    d0 = done_cnt;
    rx_in = 1'b0;
    wait_ticks(3);
    chk("fs_busy_high", 32'(rx_busy), 32'd1);
    wait_ticks(2);
    rx_in = 1'b1;
    wait_ticks(12);
    chk("fs_busy_drop", 32'(rx_busy), 32'd0);
    chk("fs_no_done", 32'(done_cnt), 32'(d0));
    chk("fs_data_hold", 32'(rx_data), 32'(last_data));

    // Back-to-back frames with no idle bit between them.
    push_exp(8'h55, 1'b1, 1'b0, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    push_exp(8'hAA, 1'b0, 1'b0, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b1);
    rx_in = 1'b1;
    wait_ticks(4);
    chk("b2b_done_count", 32'(done_cnt), 32'(expected_frames));

    // Reset in the middle of data bit 3 discards the frame.
    d0 = done_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx_in = 1'b1;
    wait_ticks(8);
    chk("mid_frame_busy", 32'(rx_busy), 32'd1);
    PRESETn = 1'b0;
    @(negedge PCLK);
    chk("abort_rx_data", 32'(rx_data), 32'd0);
    chk("abort_busy", 32'(rx_busy), 32'd0);
    chk("abort_parity", 32'(rx_parity_bit), 32'd0);
    chk("abort_ferr", 32'(framing_error), 32'd0);
    chk("abort_pulses", 32'({rx_done, error_check_en}), 32'd0);
    wait_ticks(2);
    PRESETn = 1'b1;
    last_data = 8'h00;
    wait_ticks(20);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    push_exp(8'h81, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1);
    wait_ticks(4);
    chk("post_abort_done", 32'(done_cnt), 32'(expected_frames));

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-tick glitch at the middle of data bit 2 is outvoted.
    push_exp(8'hC3, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx_in = 1'b0;
    wait_ticks(8);
    rx_in = 1'b1;
    wait_ticks(1);
    rx_in = 1'b0;
    wait_ticks(7);
    for (int i = 3; i < DB; i++) send_bit(((8'hC3 >> i) & 8'h01) != 8'h00);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_ticks(4);
    chk("glitch_done", 32'(done_cnt), 32'(expected_frames));
`endif

    // Random frames against the frame-level model.
    for (int n = 0; n < 20; n++) begin
      rd = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      push_exp(rd, rp, ~rs, ^rd ^ rp);
      send_frame(rd, rp, rs);
      rx_in = 1'b1;
      wait_ticks(rs ? int'($urandom_range(0, 6)) : 24);
    end

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) wait_ticks(1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("total_done", 32'(done_cnt), 32'(expected_frames));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
